// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- byte receiver for the single-wire serial link (far end of uart_tx)
//
// Frame on rx: start bit (0), 8 data bits MSB first, stop bit (1); idle high.
// Each bit is sampled once, near its middle, using a per-bit timing counter.
// Received bytes are offered on a valid/ready holding register.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1). Default 1 matches uart_tx.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous, active-high reset
//   rx         in   serial line, idle high
//   data       out  [7:0] received byte, stable while valid=1
//   valid      out  data holds an unconsumed byte
//   ready      in   consumer takes data this cycle when valid&ready
//   frame_err  out  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    out  one-cycle pulse: good byte arrived while holding register
//                   was full and not being read; new byte dropped
//
// Build option:
//   UART_RX_SYNC_EN  when defined, rx goes through a 2-flop synchronizer
//                    (reset to 1) before any other logic; every latency grows
//                    by 2 cycles. Use it when rx comes from off-chip.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    // Half-bit offset from the start edge to the middle of the start bit.
    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = (H > 0) ? TW'(H - 1) : '0;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_s;
    logic            commit;
    logic            consume;

`ifdef UART_RX_SYNC_EN
    // Two-stage synchronizer; resets to the idle level so reset release never
    // presents a false low to the receiver.
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    assign consume = valid_q & ready;

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        commit      = 1'b0;

        case (state_q)
            // Only leave once the line is seen high, so a line stuck low after
            // reset or a bad frame is never taken as a start bit.
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (!rx_s) begin
                    if (H == 0) begin
                        // No room for a mid-start check: go straight to data.
                        state_d = ST_DATA;
                        tcnt_d  = T_FULL;
                        bidx_d  = 3'd7;
                    end else begin
                        state_d = ST_START;
                        tcnt_d  = T_HALF;
                    end
                end
            end

            ST_START: begin
                if (tcnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        tcnt_d  = T_FULL;
                        bidx_d  = 3'd7;
                    end else begin
                        // Low pulse shorter than half a bit: ignore it.
                        state_d = ST_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (tcnt_q == '0) begin
                    shift_d[bidx_q] = rx_s;
                    tcnt_d          = T_FULL;
                    if (bidx_q == 3'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        bidx_d = bidx_q - 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end

            ST_STOP: begin
                if (tcnt_q == '0) begin
                    if (rx_s) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        // Holding register: a commit may land in the same cycle the consumer
        // drains the previous byte; otherwise a full register drops the byte.
        if (commit) begin
            if (!valid_q || consume) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_WAIT_IDLE;
            tcnt_q      <= '0;
            bidx_q      <= 3'd7;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
// Two instances: u_rx1 (1 clock/bit) and u_rx4 (4 clocks/bit).
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// i.e. after the edge has settled and well before the next one.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       rx1, ready1, rx4, ready4;
    logic [7:0] data1, data4;
    logic       valid1, valid4, ferr1, ferr4, ovr1, ovr4;

    int compared   = 0;
    int mismatched = 0;
    int ferr1_cnt  = 0;
    int ovr1_cnt   = 0;
    int ferr4_cnt  = 0;
    int ovr4_cnt   = 0;

    always #5 CLK = ~CLK;

    uart_rx #(.CLKS_PER_BIT(1)) u_rx1 (
        .CLK(CLK), .RESET(RESET), .rx(rx1), .data(data1), .valid(valid1),
        .ready(ready1), .frame_err(ferr1), .overrun(ovr1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) u_rx4 (
        .CLK(CLK), .RESET(RESET), .rx(rx4), .data(data4), .valid(valid4),
        .ready(ready4), .frame_err(ferr4), .overrun(ovr4)
    );

    // Pulse counters for the one-cycle flags.
    always @(negedge CLK) begin
        if (ferr1) ferr1_cnt <= ferr1_cnt + 1;
        if (ovr1)  ovr1_cnt  <= ovr1_cnt + 1;
        if (ferr4) ferr4_cnt <= ferr4_cnt + 1;
        if (ovr4)  ovr4_cnt  <= ovr4_cnt + 1;
    end

    typedef struct {
        logic [7:0] payload;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel4, input logic v, input int cycles);
        if (sel4) rx4 = v;
        else      rx1 = v;
        repeat (cycles) tick();
    endtask

    // Start bit plus 8 data bits MSB first; the caller drives the stop bit.
    task automatic head(input bit sel4, input logic [7:0] b, input int cpb);
        drive(sel4, 1'b0, cpb);
        for (int i = 7; i >= 0; i--) drive(sel4, b[i], cpb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};

        RESET = 1'b1; rx1 = 1'b1; rx4 = 1'b1; ready1 = 1'b0; ready4 = 1'b0;
        repeat (3) tick();
        chk("reset_valid1", valid1, 0);
        chk("reset_data1",  data1,  0);
        chk("reset_ferr1",  ferr1,  0);
        chk("reset_ovr1",   ovr1,   0);
        chk("reset_valid4", valid4, 0);
        RESET = 1'b0;
        repeat (2) tick();

        // ---------------- table-driven single frames, 1 clk/bit ----------
        for (int i = 0; i < 7; i++) begin
            head(0, vecs[i].payload, 1);
            chk("pre_stop_valid", valid1, 0);
            drive(0, vecs[i].stop, 1);
            chk("frame_valid", valid1, 32'(vecs[i].exp_valid));
            chk("frame_ferr",  ferr1,  32'(vecs[i].exp_ferr));
            chk("frame_ovr",   ovr1,   0);
            if (vecs[i].exp_valid) chk("frame_data", data1, 32'(vecs[i].exp_data));
            $display("vec %0d: sent 0x%02h stop=%0d -> valid=%0d data=0x%02h frame_err=%0d",
                     i, vecs[i].payload, vecs[i].stop, valid1, data1, ferr1);
            drive(0, 1'b1, 1);
            chk("ferr_one_cycle", ferr1, 0);
            if (vecs[i].exp_valid) begin
                ready1 = 1'b1;
                tick();
                ready1 = 1'b0;
                chk("consume_valid", valid1, 0);
            end
            drive(0, 1'b1, 2);
        end

        // ---------------- back-to-back 0x00 then 0xFF, ready held --------
        o0 = ovr1_cnt;
        ready1 = 1'b1;
        head(0, 8'h00, 1);
        drive(0, 1'b1, 1);
        chk("b2b_valid0", valid1, 1);
        chk("b2b_data0",  data1,  8'h00);
        drive(0, 1'b0, 1);
        chk("b2b_drained", valid1, 0);
        for (int i = 7; i >= 0; i--) drive(0, 1'(8'hFF >> i), 1);
        drive(0, 1'b1, 1);
        chk("b2b_valid1", valid1, 1);
        chk("b2b_data1",  data1,  8'hFF);
        $display("b2b: 0x00 then 0x%02h received 10 cycles apart", data1);
        tick();
        ready1 = 1'b0;
        chk("b2b_no_ovr", ovr1_cnt, o0);
        drive(0, 1'b1, 2);

        // ---------------- overrun: 0x11 held, 0x22 dropped ---------------
        o0 = ovr1_cnt;
        head(0, 8'h11, 1);
        drive(0, 1'b1, 1);
        chk("ovr_valid_first", valid1, 1);
        chk("ovr_data_first",  data1,  8'h11);
        head(0, 8'h22, 1);
        drive(0, 1'b1, 1);
        chk("ovr_pulse",      ovr1,  1);
        chk("ovr_data_kept",  data1, 8'h11);
        chk("ovr_valid_kept", valid1, 1);
        chk("ovr_no_ferr",    ferr1, 0);
        $display("overrun: held 0x%02h, overrun=%0d", data1, ovr1);
        tick();
        chk("ovr_one_cycle", ovr1, 0);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("ovr_drain_valid", valid1, 0);
        chk("ovr_drain_data",  data1,  8'h11);
        chk("ovr_count", ovr1_cnt, o0 + 1);
        drive(0, 1'b1, 2);

        // ---------------- frame error, line stuck low, then 0x81 ---------
        f0 = ferr1_cnt;
        head(0, 8'h3C, 1);
        drive(0, 1'b0, 1);
        chk("fe_pulse", ferr1,  1);
        chk("fe_valid", valid1, 0);
        drive(0, 1'b0, 12);
        chk("fe_low_valid", valid1, 0);
        chk("fe_count", ferr1_cnt, f0 + 1);
        drive(0, 1'b1, 1);
        head(0, 8'h81, 1);
        drive(0, 1'b1, 1);
        chk("fe_next_valid", valid1, 1);
        chk("fe_next_data",  data1,  8'h81);
        $display("after frame error: received 0x%02h", data1);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        drive(0, 1'b1, 2);

        // ---------------- 4 clocks/bit: 0xC3 then a glitch ---------------
        head(1, 8'hC3, 4);
        chk("cpb4_pre_stop", valid4, 0);
        drive(1, 1'b1, 4);
        chk("cpb4_valid", valid4, 1);
        chk("cpb4_data",  data4,  8'hC3);
        $display("cpb4: received 0x%02h", data4);
        ready4 = 1'b1;
        tick();
        ready4 = 1'b0;
        chk("cpb4_drain", valid4, 0);
        drive(1, 1'b0, 1);
        drive(1, 1'b1, 12);
        chk("cpb4_glitch_valid", valid4, 0);
        chk("cpb4_glitch_ferr",  ferr4_cnt, 0);
        chk("cpb4_glitch_ovr",   ovr4_cnt,  0);
        $display("cpb4 glitch: valid=%0d", valid4);

        // ---------------- reset mid-frame ---------------------------------
        head(0, 8'hE7, 1);
        drive(0, 1'b1, 1);
        chk("rst_pre_valid", valid1, 1);
        f0 = ferr1_cnt;
        drive(0, 1'b0, 1);
        for (int i = 7; i >= 4; i--) drive(0, 1'(8'h5A >> i), 1);
        rx1 = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_async_valid", valid1, 0);
        chk("rst_async_data",  data1,  0);
        chk("rst_async_ferr",  ferr1,  0);
        chk("rst_async_ovr",   ovr1,   0);
        tick();
        RESET = 1'b0;
        drive(0, 1'b0, 12);
        chk("rst_low_valid", valid1, 0);
        chk("rst_low_ferr",  ferr1_cnt, f0);
        drive(0, 1'b1, 1);
        head(0, 8'h5A, 1);
        drive(0, 1'b1, 1);
        chk("rst_after_valid", valid1, 1);
        chk("rst_after_data",  data1,  8'h5A);
        $display("after reset: received 0x%02h", data1);
        drive(0, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Byte receiver for the team's single-wire serial link; it is the far end of the existing uart_tx.
- Frame, in order: 1 start bit (0), 8 data bits MSB first (bit 7 first, bit 0 last), 1 stop bit (1). Line idles high.
- Recovers bytes from rx and presents them on a valid/ready output port, with framing-error and overrun reporting.
- Default bit timing (1 clock per bit) matches uart_tx directly, with no divider.

Parameters:
CLKS_PER_BIT, 1, clock cycles per serial bit; legal range >= 1.

Ports:
CLK  input  1  system clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
rx  input  1  serial line; idle high.
data  output  8  received byte; stable while valid=1.
valid  output  1  data holds an unconsumed byte.
ready  input  1  consumer accepts data this cycle when valid&ready.
frame_err  output  1  one-cycle pulse: stop bit sampled as 0, byte discarded.
overrun  output  1  one-cycle pulse: a good byte completed while the holding register was full and not being read; new byte dropped.

Behaviour:
- Reset (async assert, any state): state=WAIT_IDLE, data=0, valid=0, frame_err=0, overrun=0, bit counter=7, timing counter=0. A frame in progress is abandoned.
- Let H = (CLKS_PER_BIT-1)/2 (integer division). Sampling point is the middle of each bit.
- WAIT_IDLE: stay until rx=1, then go to IDLE. Entered after reset or a framing error, so a low line is never mistaken for a start bit.
- IDLE: on rx=0:
  - if H=0, go to DATA with tcnt=CLKS_PER_BIT-1 and bidx=7;
  - otherwise go to START with tcnt=H-1.
- START: decrement tcnt. At tcnt=0, sample rx:
  - rx=0: go to DATA with tcnt=CLKS_PER_BIT-1 and bidx=7;
  - rx=1: glitch; return to IDLE with no output.
- DATA: decrement tcnt. At tcnt=0:
  - shift rx into shift[bidx] and reload tcnt=CLKS_PER_BIT-1;
  - if bidx=0, go to STOP; else bidx-=1.
- STOP: at tcnt=0, sample rx:
  - rx=1: commit the byte and go to IDLE;
  - rx=0: frame_err=1 for one cycle, no commit, go to WAIT_IDLE.
- Commit, effective the cycle after the stop sample:
  - if valid=0, or valid&ready in the commit cycle: data<=shift, valid<=1;
  - else: overrun pulses, data and valid unchanged.
- Consume: valid&ready with no simultaneous commit → valid<=0 next cycle; data retains its value.
- Latency at CLKS_PER_BIT=1: start bit seen at cycle t → data bits at t+1..t+8 → stop at t+9 → valid=1 from t+10. A new start may be accepted at t+10 (back-to-back frames supported).
- frame_err and overrun are mutually exclusive in a cycle and are never held high.
- rx changes outside sampling points are ignored.

Optional Feature:
Macro UART_RX_SYNC_EN.
- Defined: rx passes through a 2-flop synchronizer, reset to 1, before all logic. All latencies above grow by 2 cycles. Required when rx comes from off-chip.
- Undefined: rx is used directly, with the timing exactly as above. For on-chip loopback from uart_tx.

Test Plan:
- Reset, idle rx=1, CLKS_PER_BIT=1; drive 0,1,0,1,0,0,1,0,1,1 (0xA5) → valid=1 at 10 cycles after the start bit, data=0xA5, frame_err=0.
- Back-to-back 0x00 then 0xFF with ready held 1 → two valid pulses 10 cycles apart, data 0x00 then 0xFF, no overrun.
- 0x3C with stop bit forced 0 → frame_err pulses once, valid stays 0. A following correct 0x81 is received only after rx returns high.
- ready=0; send 0x11 then 0x22 → valid=1, data=0x11, overrun pulses once at the 0x22 commit. Raise ready → valid drops next cycle.
- CLKS_PER_BIT=4: 0xC3 sent at 4 clocks/bit → data=0xC3. A 1-cycle low glitch on an idle line produces no output.
- RESET asserted mid-frame (after bit 4) with rx held 0 → outputs 0 immediately. After release, no byte until rx=1 then a full 0x5A frame → data=0x5A.
